ifq: RTL and testbench

// - Instruction fetch queue: buffers 64-bit fetch groups from the I-side memory path and presents one
//   32-bit instruction per cycle, plus its PC and page-fault flag, to the combinational decoder (du).
// - Sits between the fetch unit and the decode stage.
// - Absorbs fetch latency and backpressure, and discards stale groups on redirect.

---
 rtl/ifq_pkg.sv | 26 ++
 rtl/ifq_ram.sv | 29 ++
 rtl/ifq.sv | 124 ++++++++++++
 tb/tb_ifq.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ifq_pkg.sv
// ifq_pkg: shared types and constants for the instruction fetch queue.
//   IFQ_GRP_W   : width of one fetch group (two 32-bit instructions)
//   IFQ_PC_W    : stored PC bits (pc[63:3], group aligned)
//   IFQ_ENTRY_W : width of one stored entry {pc, data, pf, hvalid}
//   HV_*        : half-valid encodings (bit0 = low half, bit1 = high half)
package ifq_pkg;
   localparam int IFQ_GRP_W   = 64;
   localparam int IFQ_PC_W    = 61;
   localparam int IFQ_ENTRY_W = 128;

   localparam logic [1:0] HV_NONE = 2'b00;
   localparam logic [1:0] HV_HIGH = 2'b10;
   localparam logic [1:0] HV_BOTH = 2'b11;

   typedef struct packed {
      logic [IFQ_PC_W-1:0]  pc;
      logic [IFQ_GRP_W-1:0] data;
      logic                 pf;
      logic [1:0]           hvalid;
   } ifq_entry_t;

   // Consuming a half always takes the lowest remaining one.
   function automatic logic [1:0] hv_clear_low(input logic [1:0] hv);
      return hv & (hv - 2'd1);
   endfunction
endpackage

// File: rtl/ifq_ram.sv
// ifq_ram: DEPTH x IFQ_ENTRY_W register array, one write port, one
// asynchronous read port.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational)
module ifq_ram
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                   clk,
   input  logic                   we_i,
   input  logic [PTR_W-1:0]       waddr_i,
   input  logic [IFQ_ENTRY_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]       raddr_i,
   output logic [IFQ_ENTRY_W-1:0] rdata_o
);
   logic [IFQ_ENTRY_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ifq.sv
// ifq: instruction fetch queue. Buffers 64-bit fetch groups and presents one
// 32-bit instruction per cycle with its PC and page-fault flag to decode.
// Optional feature macro: IFQ_BYPASS_EN (same-cycle bypass into an empty queue).
//   clk, rst        : clock, synchronous active-high reset
//   flush           : redirect, drops everything queued
//   in_valid/ready  : fetch group handshake; in_pc, in_data, in_page_fault
//   out_valid/ready : instruction handshake; out_instr, out_pc, out_page_fault
module ifq
   import ifq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_pc,
   input  logic [63:0] in_data,
   input  logic        in_page_fault,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [63:0] out_pc,
   output logic        out_page_fault
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [1:0]       hv_q [DEPTH];

   ifq_entry_t rd_entry, wr_entry;
   logic [1:0] head_hv, push_hv_raw, push_hv, src_hv;
   logic       store_valid, push, push_alloc, pop, retire;
   logic       byp, sel_high, src_pf;
   logic [IFQ_PC_W-1:0]  src_pc;
   logic [IFQ_GRP_W-1:0] src_data;
   logic [31:0]          half;
   logic                 unused_pc_lsbs;

   assign unused_pc_lsbs = ^in_pc[1:0];

   assign store_valid = (count_q != '0);
   assign in_ready    = !rst && (count_q != FULL);
   assign push        = in_valid && in_ready && !flush;
   assign push_hv_raw = in_pc[2] ? HV_HIGH : HV_BOTH;

`ifdef IFQ_BYPASS_EN
   // Empty queue: present the incoming group directly; a same-cycle consume
   // is folded into the hvalid written for the new entry.
   assign byp     = push && !store_valid;
   assign push_hv = (byp && out_ready) ? hv_clear_low(push_hv_raw) : push_hv_raw;
`else
   assign byp     = 1'b0;
   assign push_hv = push_hv_raw;
`endif

   assign push_alloc = push && (push_hv != HV_NONE);

   assign wr_entry = '{pc: in_pc[63:3], data: in_data, pf: in_page_fault, hvalid: push_hv};

   ifq_ram #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_ram (
      .clk     (clk),
      .we_i    (push_alloc),
      .waddr_i (wptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rptr_q),
      .rdata_o (rd_entry)
   );

   // hv_q is authoritative (it is cleared by flush); the stored copy only
   // masks it so both must agree that a half is still pending.
   assign head_hv = hv_q[rptr_q] & rd_entry.hvalid;

   assign pop    = store_valid && out_ready;
   assign retire = pop && (hv_clear_low(head_hv) == HV_NONE);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_hv
         always_ff @(posedge clk) begin
            if (rst || flush)
               hv_q[gi] <= HV_NONE;
            else if (push_alloc && (wptr_q == PTR_W'(gi)))
               hv_q[gi] <= push_hv;
            else if (pop && (rptr_q == PTR_W'(gi)))
               hv_q[gi] <= hv_clear_low(hv_q[gi]);
         end
      end
   endgenerate

   always_comb begin
      wptr_d  = push_alloc ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = retire ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q + (PTR_W+1)'(push_alloc) - (PTR_W+1)'(retire);
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Output source: storage head when occupied, otherwise the incoming group.
   assign src_pc   = store_valid ? rd_entry.pc   : in_pc[63:3];
   assign src_data = store_valid ? rd_entry.data : in_data;
   assign src_pf   = store_valid ? rd_entry.pf   : in_page_fault;
   assign src_hv   = store_valid ? head_hv       : push_hv_raw;
   assign sel_high = !src_hv[0];
   assign half     = sel_high ? src_data[63:32] : src_data[31:0];

   assign out_valid      = store_valid || byp;
   assign out_instr      = (out_valid && !src_pf) ? half : 32'h0;
   assign out_page_fault = out_valid && src_pf;
   assign out_pc         = out_valid ? {src_pc, sel_high, 2'b00} : 64'h0;
endmodule

// File: tb/tb_ifq.sv
module tb_ifq;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_page_fault;
   logic [63:0] in_pc, in_data, out_pc;
   logic        out_valid, out_ready, out_page_fault;
   logic [31:0] out_instr;
   int          checks = 0;
   int          errors = 0;
   logic        push_rdy;

   ifq #(.DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
      .in_page_fault(in_page_fault),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_page_fault(out_page_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("chk %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                          input logic [63:0] pc, input logic pf);
      chk({tag, ".valid"}, 64'(out_valid), 64'(v));
      chk({tag, ".instr"}, 64'(out_instr), 64'(ins));
      chk({tag, ".pc"}, out_pc, pc);
      chk({tag, ".pf"}, 64'(out_page_fault), 64'(pf));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef IFQ_BYPASS_EN
      push_rdy = 1'b0;
`else
      push_rdy = 1'b1;
`endif
      rst = 1; flush = 0; in_valid = 0; in_pc = '0; in_data = '0;
      in_page_fault = 0; out_ready = 0;
      tick(); tick();
      #1;
      chk("rst.in_ready", 64'(in_ready), 64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      tick();
      rst = 0;
      #1;
      chk("post_rst.in_ready", 64'(in_ready), 64'd1);
      chk_out("post_rst", 1'b0, 32'h0, 64'h0, 1'b0);

      // Two halves in PC order from one group.
      in_valid = 1; in_pc = 64'h1000; in_data = 64'h00500093_00100013; out_ready = push_rdy;
      #1;
`ifndef IFQ_BYPASS_EN
      chk("t1.latency", 64'(out_valid), 64'd0);
`endif
      tick();
      in_valid = 0; out_ready = 1;
      #1; chk_out("t1.lo", 1'b1, 32'h00100013, 64'h1000, 1'b0);
      tick(); chk_out("t1.hi", 1'b1, 32'h00500093, 64'h1004, 1'b0);
      tick(); chk("t1.empty", 64'(out_valid), 64'd0);

      // Skipped low half.
      in_valid = 1; in_pc = 64'h2004; in_data = 64'hAAAA0001_BBBB0002; out_ready = push_rdy;
      tick();
      in_valid = 0; out_ready = 1;
      #1; chk_out("t2.hi", 1'b1, 32'hAAAA0001, 64'h2004, 1'b0);
      tick(); chk("t2.empty", 64'(out_valid), 64'd0);

      // Fill, hold a 5th push, then drain across pointer wrap.
      out_ready = 0;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1;
         in_pc    = 64'h4000 + 64'(8 * k);
         in_data  = {32'h10000000 + 32'(2 * k + 1), 32'h10000000 + 32'(2 * k)};
         #1; chk($sformatf("t3.in_ready%0d", k), 64'(in_ready), 64'd1);
         tick();
      end
      in_pc = 64'h4020; in_data = {32'h10000009, 32'h10000008};
      #1; chk("t3.full", 64'(in_ready), 64'd0);
      tick();
      chk("t3.full_held", 64'(in_ready), 64'd0);
      out_ready = 1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) in_valid = 0;
         #1;
         chk_out($sformatf("t3.pop%0d", i), 1'b1, 32'h10000000 + 32'(i),
                 64'h4000 + 64'(4 * i), 1'b0);
         if (i < 2) chk($sformatf("t3.rdy%0d", i), 64'(in_ready), 64'd0);
         if (i == 2) chk("t3.rdy2", 64'(in_ready), 64'd1);
         tick();
      end
      chk("t3.empty", 64'(out_valid), 64'd0);

      // Flush with 3 queued and a simultaneous push.
      out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1; in_pc = 64'h5000 + 64'(8 * k); in_data = 64'h12345678_9ABCDEF0;
         tick();
      end
      chk("t4.queued", 64'(out_valid), 64'd1);
      flush = 1; in_pc = 64'h6000; in_data = 64'hDEADBEEF_CAFEF00D;
      tick();
      flush = 0; in_valid = 0;
      #1;
      chk("t4.out_valid", 64'(out_valid), 64'd0);
      chk("t4.in_ready", 64'(in_ready), 64'd1);
      out_ready = 1;
      tick(); chk("t4.gone", 64'(out_valid), 64'd0);

      // Page-faulted group: two zeroed, faulting outputs.
      in_valid = 1; in_pc = 64'h3000; in_data = 64'h11112222_33334444;
      in_page_fault = 1; out_ready = push_rdy;
      tick();
      in_valid = 0; in_page_fault = 0; out_ready = 1;
      #1; chk_out("t5.lo", 1'b1, 32'h0, 64'h3000, 1'b1);
      tick(); chk_out("t5.hi", 1'b1, 32'h0, 64'h3004, 1'b1);
      tick(); chk_out("t5.empty", 1'b0, 32'h0, 64'h0, 1'b0);

`ifdef IFQ_BYPASS_EN
      in_valid = 1; in_pc = 64'h7000; in_data = 64'h77770001_77770000; out_ready = 1;
      #1; chk_out("t6.byp", 1'b1, 32'h77770000, 64'h7000, 1'b0);
      tick();
      in_valid = 0;
      #1; chk_out("t6.hi", 1'b1, 32'h77770001, 64'h7004, 1'b0);
      tick(); chk("t6.empty", 64'(out_valid), 64'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
